// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core and its instruction-memory loader.
package riscv_pkg;
   localparam int XLEN        = 32;
   localparam int IMEM_DEPTH  = 32;
   localparam int IMEM_ADDR_W = 5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } loader_state_e;
endpackage

// File: rtl/imem_word_packer.sv
// Packs four little-endian stream bytes into one instruction word.
// The first byte of a word ends up in [7:0]. last_o flags the shift that completes a word.
module imem_word_packer
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clear_i,
   input  logic            shift_i,
   input  logic [7:0]      byte_i,
   output logic [XLEN-1:0] word_nxt_o,
   output logic            last_o
);

   // Only three earlier bytes are ever needed; the fourth comes straight from byte_i.
   logic [XLEN-9:0] word_q;
   logic [1:0]      cnt_q;

   assign word_nxt_o = {byte_i, word_q};
   assign last_o     = shift_i && (cnt_q == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 2'd0;
      end else if (clear_i) begin
         cnt_q <= 2'd0;
      end else if (shift_i) begin
         cnt_q <= cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (shift_i) begin
         word_q <= word_nxt_o[XLEN-1:8];
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory write port.
// Stream: word count N, then N little-endian words; cpu_hold releases only after the last write.
module imem_loader
   import riscv_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [XLEN-1:0]   wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold
);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]   wr_data_q, wr_data_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic              cpu_hold_q, cpu_hold_d;

   logic              xfer;
   logic              len_bad;
   logic              start_ok;
   logic [ADDR_W:0]   addr_inc;
   logic              last_word;
   logic              pk_clear;
   logic              pk_shift;
   logic              pk_last;
   logic [XLEN-1:0]   pk_word;

   assign xfer      = byte_valid && byte_ready;
   assign len_bad   = (byte_data == 8'd0) || (int'(byte_data) > DEPTH);
   assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign addr_inc  = {1'b0, wr_addr_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign last_word = (addr_inc == n_q);
   assign pk_clear  = start_ok;
   assign pk_shift  = (state_q == S_DATA) && xfer;

   imem_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (pk_clear),
      .shift_i    (pk_shift),
      .byte_i     (byte_data),
      .word_nxt_o (pk_word),
      .last_o     (pk_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         n_q        <= '0;
         cpu_hold_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         n_q        <= n_d;
         cpu_hold_q <= cpu_hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_LEN;
         S_LEN:   if (xfer) state_d = len_bad ? S_ERR : S_DATA;
         S_DATA:  if (pk_last) state_d = S_WRITE;
         S_WRITE: state_d = last_word ? S_DONE : S_DATA;
         S_DONE:  if (start) state_d = S_LEN;
         S_ERR:   if (start) state_d = S_LEN;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next-state: address, packed word, word count and the hold flag.
   always_comb begin
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      n_d        = n_q;
      if (start_ok) begin
         wr_addr_d = '0;
      end
      if ((state_q == S_LEN) && xfer && !len_bad) begin
         n_d = byte_data[ADDR_W:0];
      end
      if (pk_last) begin
         wr_data_d = pk_word;
      end
      if ((state_q == S_WRITE) && !last_word) begin
         wr_addr_d = addr_inc[ADDR_W-1:0];
      end
      // Dropping together with the DONE transition keeps the hold up through the final strobe.
      cpu_hold_d = (state_d != S_DONE);
   end

   always_comb begin
      byte_ready = (state_q == S_LEN) || (state_q == S_DATA);
      wr_en      = (state_q == S_WRITE);
      busy       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
      done       = (state_q == S_DONE);
      err        = (state_q == S_ERR);
      wr_addr    = wr_addr_q;
      wr_data    = wr_data_q;
      cpu_hold   = cpu_hold_q;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the basic load and length errors,
// plus hand sequences for gapped streams, mid-load reset and a full-depth image.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, wr_en, busy, done, err, cpu_hold;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int checks = 0;
   int errors = 0;

   logic [4:0]  wq_addr[$];
   logic [31:0] wq_data[$];

   imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor; also checks that byte_ready is low exactly in the WRITE cycles of a load.
   always @(negedge clk) begin
      #2;
      if (!rst && wr_en) begin
         wq_addr.push_back(wr_addr);
         wq_data.push_back(wr_data);
      end
      if (!rst && busy) chk("ready_vs_write", {31'd0, byte_ready}, {31'd0, !wr_en});
   end

   typedef struct {
      logic        st;
      logic        vld;
      logic [7:0]  dat;
      logic        rdy;
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] wdat;
      logic        bsy;
      logic        dn;
      logic        er;
      logic        hold;
   } vec_t;

   function automatic vec_t mk(logic st, logic vld, logic [7:0] dat, logic rdy, logic wen,
                               logic [4:0] addr, logic [31:0] wdat, logic bsy, logic dn,
                               logic er, logic hold);
      vec_t v;
      v.st = st; v.vld = vld; v.dat = dat; v.rdy = rdy; v.wen = wen; v.addr = addr;
      v.wdat = wdat; v.bsy = bsy; v.dn = dn; v.er = er; v.hold = hold;
      return v;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      byte_valid = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gaps, input logic st);
      int  k;
      bit  got;
      for (int g = 0; g < gaps; g++) begin
         @(negedge clk);
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         start      = st;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      start      = st;
      k   = 0;
      got = 1'b0;
      while (!got && k < 20) begin
         #1 got = byte_ready;
         @(posedge clk);
         k++;
         if (!got) @(negedge clk);
      end
      if (!got) chk("byte_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      byte_valid = 1'b0;
      start = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         #1 seen = done;
         if (!seen) @(negedge clk);
      end
      chk("done_reached", {31'd0, seen}, 32'd1);
   endtask

   task automatic send_two_word_image(input bit gapped);
      logic [7:0] img [9];
      img = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      for (int i = 0; i < 9; i++) send_byte(img[i], gapped ? int'($urandom_range(0, 3)) : 0, 1'b0);
   endtask

   task automatic check_two_writes(input string tag);
      chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'd2);
      if (wq_addr.size() == 2) begin
         chk({tag, "_a0"}, {27'd0, wq_addr[0]}, 32'd0);
         chk({tag, "_d0"}, wq_data[0], 32'h0000_0013);
         chk({tag, "_a1"}, {27'd0, wq_addr[1]}, 32'd1);
         chk({tag, "_d1"}, wq_data[1], 32'h0010_0093);
      end
   endtask

   vec_t tbl [19];

   initial begin
      tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0, 32'h0,           0, 0, 0, 1);
      tbl[1]  = mk(0, 1, 8'h02, 1, 0, 0, 32'h0,           1, 0, 0, 1);
      tbl[2]  = mk(0, 1, 8'h13, 1, 0, 0, 32'h0,           1, 0, 0, 1);
      tbl[3]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,           1, 0, 0, 1);
      tbl[4]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,           1, 0, 0, 1);
      tbl[5]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,           1, 0, 0, 1);
      tbl[6]  = mk(1, 1, 8'h93, 0, 1, 0, 32'h0000_0013,   1, 0, 0, 1);
      tbl[7]  = mk(0, 1, 8'h93, 1, 0, 1, 32'h0000_0013,   1, 0, 0, 1);
      tbl[8]  = mk(0, 1, 8'h00, 1, 0, 1, 32'h0000_0013,   1, 0, 0, 1);
      tbl[9]  = mk(0, 1, 8'h10, 1, 0, 1, 32'h0000_0013,   1, 0, 0, 1);
      tbl[10] = mk(0, 1, 8'h00, 1, 0, 1, 32'h0000_0013,   1, 0, 0, 1);
      tbl[11] = mk(0, 0, 8'h00, 0, 1, 1, 32'h0010_0093,   1, 0, 0, 1);
      tbl[12] = mk(0, 1, 8'hff, 0, 0, 1, 32'h0010_0093,   0, 1, 0, 0);
      tbl[13] = mk(1, 0, 8'h00, 0, 0, 1, 32'h0010_0093,   0, 1, 0, 0);
      tbl[14] = mk(0, 1, 8'h00, 1, 0, 0, 32'h0010_0093,   1, 0, 0, 1);
      tbl[15] = mk(1, 0, 8'h00, 0, 0, 0, 32'h0010_0093,   0, 0, 1, 1);
      tbl[16] = mk(0, 1, 8'h21, 1, 0, 0, 32'h0010_0093,   1, 0, 0, 1);
      tbl[17] = mk(0, 0, 8'h00, 0, 0, 0, 32'h0010_0093,   0, 0, 1, 1);
      tbl[18] = mk(0, 0, 8'h00, 0, 0, 0, 32'h0010_0093,   0, 0, 1, 1);

      // Reset state, with noisy inputs applied during reset
      start = 1'b1;
      byte_valid = 1'b1;
      byte_data = 8'h55;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_addr", {27'd0, wr_addr}, 32'd0);
      chk("rst_data", wr_data, 32'd0);
      start = 1'b0;
      byte_valid = 1'b0;
      rst = 1'b0;

      // Cycle table: two-word load, DONE, then zero and oversize length errors
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         start      = tbl[i].st;
         byte_valid = tbl[i].vld;
         byte_data  = tbl[i].dat;
         #1;
         chk($sformatf("t%0d_ready", i), {31'd0, byte_ready}, {31'd0, tbl[i].rdy});
         chk($sformatf("t%0d_wr_en", i), {31'd0, wr_en}, {31'd0, tbl[i].wen});
         chk($sformatf("t%0d_addr", i), {27'd0, wr_addr}, {27'd0, tbl[i].addr});
         chk($sformatf("t%0d_data", i), wr_data, tbl[i].wdat);
         chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
         chk($sformatf("t%0d_done", i), {31'd0, done}, {31'd0, tbl[i].dn});
         chk($sformatf("t%0d_err", i), {31'd0, err}, {31'd0, tbl[i].er});
         chk($sformatf("t%0d_hold", i), {31'd0, cpu_hold}, {31'd0, tbl[i].hold});
      end
      @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b0;
      check_two_writes("tbl");

      // Same image with random valid gaps
      wq_addr.delete();
      wq_data.delete();
      pulse_start();
      send_two_word_image(1'b1);
      wait_done(40);
      check_two_writes("gap");
      chk("gap_hold", {31'd0, cpu_hold}, 32'd0);

      // Reset after five bytes of a two-word load
      wq_addr.delete();
      wq_data.delete();
      pulse_start();
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h13, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h93, 0, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_ready", {31'd0, byte_ready}, 32'd0);
      chk("mrst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("mrst_addr", {27'd0, wr_addr}, 32'd0);
      chk("mrst_data", wr_data, 32'd0);
      chk("mrst_pre_wr", 32'(wq_addr.size()), 32'd1);
      wq_addr.delete();
      wq_data.delete();
      @(negedge clk);
      byte_valid = 1'b0;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("mrst_no_wr", 32'(wq_addr.size()), 32'd0);
      chk("mrst_idle_busy", {31'd0, busy}, 32'd0);
      pulse_start();
      send_two_word_image(1'b0);
      wait_done(40);
      check_two_writes("fresh");

      // Full-depth image; start is pulsed during the load and must be ignored
      wq_addr.delete();
      wq_data.delete();
      pulse_start();
      send_byte(8'h20, 0, 1'b0);
      for (int w = 0; w < 32; w++) begin
         logic [31:0] word;
         word = {8'(w), 8'hA5, 8'(w * 3), 8'h13};
         for (int b = 0; b < 4; b++) send_byte(word[8*b +: 8], 0, (w == 10) && (b < 2));
      end
      wait_done(40);
      chk("full_nwr", 32'(wq_addr.size()), 32'd32);
      if (wq_addr.size() == 32) begin
         for (int w = 0; w < 32; w++) begin
            chk($sformatf("full_a%0d", w), {27'd0, wq_addr[w]}, 32'(w));
            chk($sformatf("full_d%0d", w), wq_data[w], {8'(w), 8'hA5, 8'(w * 3), 8'h13});
         end
      end
      chk("full_last_addr", {27'd0, wr_addr}, 32'd31);
      chk("full_done", {31'd0, done}, 32'd1);
      chk("full_hold", {31'd0, cpu_hold}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
